// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encoding and controller state type
package traffic_pkg;

  localparam logic [1:0] LIGHT_OFF = 2'd0;
  localparam logic [1:0] LIGHT_GRN = 2'd1;
  localparam logic [1:0] LIGHT_YEL = 2'd2;
  localparam logic [1:0] LIGHT_RED = 2'd3;

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK
  } state_t;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - sensor/request inputs and lamp outputs of the intersection
interface traffic_phase_ctrl_if #(
  parameter int NUM_PHASES = 2
);
  logic [NUM_PHASES-1:0]   sensor;
  logic                    walk_req;
  logic [2*NUM_PHASES-1:0] lights;
  logic                    walk_light;
  logic [2:0]              phase;
  logic                    walk_pending;

  // master is the controller, slave is the field side (sensors, buttons, lamps)
  modport master (
    input  sensor, walk_req,
    output lights, walk_light, phase, walk_pending
  );

  modport slave (
    output sensor, walk_req,
    input  lights, walk_light, phase, walk_pending
  );
endinterface

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - interval counter with terminal-count flag
module interval_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == target - CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - round-robin multi-phase signal controller with extension and walk
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 6,
  parameter int T_GREEN    = 6,
  parameter int T_EXT      = 3,
  parameter int T_YEL      = 2,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_phase_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] TGRN     = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] TGRN_EXT = CNT_W'(T_GREEN + T_EXT);
  localparam logic [CNT_W-1:0] TYEL     = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] TALL     = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] TWLK     = CNT_W'(T_WALK);
  localparam logic [2:0]       LAST_PH  = 3'(NUM_PHASES - 1);
  localparam bit               EXT_EN   = (T_EXT > 0);

  state_t                  state, state_n;
  logic [2:0]              phase, phase_n;
  logic                    ext_used, ext_n;
  logic                    pend, pend_n;
  logic                    sens_p, ext_grant, clr, done;
  logic [CNT_W-1:0]        cnt, target;
  logic [2*NUM_PHASES-1:0] lights_q;
  logic                    walk_light_q;

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .target (target),
    .cnt    (cnt),
    .done   (done)
  );

  always_comb begin
    sens_p = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase == 3'(i)) sens_p = bus.sensor[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_GREEN;
      phase    <= '0;
      ext_used <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      ext_used <= ext_n;
      pend     <= pend_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    ext_n     = ext_used;
    pend_n    = pend;
    target    = TGRN;
    ext_grant = 1'b0;
    case (state)
      ST_GREEN: begin
        // the grant must stretch the target in the same cycle it is decided
        ext_grant = EXT_EN && (cnt == TGRN - CNT_W'(1)) && sens_p && !ext_used;
        if (ext_grant) ext_n = 1'b1;
        target = (ext_used || ext_grant) ? TGRN_EXT : TGRN;
        if (done) state_n = ST_YELLOW;
      end
      ST_YELLOW: begin
        target = TYEL;
        if (done) state_n = ST_ALLRED;
      end
      ST_ALLRED: begin
        target = TALL;
        if (done) begin
          if (phase != LAST_PH) begin
            phase_n = phase + 3'd1;
            state_n = ST_GREEN;
          end else if (pend) begin
            state_n = ST_WALK;
          end else begin
            phase_n = '0;
            state_n = ST_GREEN;
          end
        end
      end
      ST_WALK: begin
        target = TWLK;
        if (done) begin
          phase_n = '0;
          state_n = ST_GREEN;
        end
      end
      default: state_n = ST_GREEN;
    endcase
    if (state_n == ST_GREEN && state != ST_GREEN) ext_n = 1'b0;
    if (state_n == ST_WALK && state != ST_WALK) begin
      pend_n = 1'b0;
    end else if (bus.walk_req && state != ST_WALK) begin
      pend_n = 1'b1;
    end
  end

  assign clr = (state_n != state);

  // lamps decode from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        lights_q[2*p +: 2] <= (p == 0) ? LIGHT_GRN : LIGHT_RED;
      end
      walk_light_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        lights_q[2*p +: 2] <=
          (phase_n == 3'(p) && state_n == ST_GREEN)  ? LIGHT_GRN :
          (phase_n == 3'(p) && state_n == ST_YELLOW) ? LIGHT_YEL : LIGHT_RED;
      end
      walk_light_q <= (state_n == ST_WALK);
    end
  end

  assign bus.lights       = lights_q;
  assign bus.walk_light   = walk_light_q;
  assign bus.phase        = phase;
  assign bus.walk_pending = pend;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - randomized bench for traffic_phase_ctrl against an interval-level model
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int TG = 6, TE = 3, TY = 2, TA = 1, TW = 5, NP = 2;
  localparam logic [21:0] RESET_VEC = {4'b1101, 1'b0, 3'd0, 1'b0, 8'b11111101, 1'b0, 3'd0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.NUM_PHASES(2)) bus ();
  traffic_phase_ctrl_if #(.NUM_PHASES(4)) bus4 ();

  traffic_phase_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  traffic_phase_ctrl #(.NUM_PHASES(4), .T_EXT(0)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int checks = 0;
  int failures = 0;

  // model of the 2-phase unit: segment kind (0 green,1 yellow,2 all-red,3 walk), elapsed and length
  int m_seg, m_phase, m_el, m_len;
  bit m_ext, m_pend;
  int t4;

  task automatic model_reset();
    m_seg = 0; m_phase = 0; m_el = 0; m_len = TG; m_ext = 0; m_pend = 0; t4 = 0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic w);
    bit was_walk, enter_walk;
    was_walk = (m_seg == 3);
    enter_walk = 0;
    if (m_seg == 0 && m_el == TG - 1 && s[m_phase] && TE > 0 && !m_ext) begin
      m_ext = 1;
      m_len = TG + TE;
    end
    m_el++;
    if (m_el == m_len) begin
      m_el = 0;
      case (m_seg)
        0: begin m_seg = 1; m_len = TY; end
        1: begin m_seg = 2; m_len = TA; end
        2: begin
          if (m_phase < NP - 1) begin m_phase++; m_seg = 0; m_len = TG; m_ext = 0; end
          else if (m_pend) begin m_seg = 3; m_len = TW; enter_walk = 1; end
          else begin m_phase = 0; m_seg = 0; m_len = TG; m_ext = 0; end
        end
        default: begin m_phase = 0; m_seg = 0; m_len = TG; m_ext = 0; end
      endcase
    end
    if (enter_walk) m_pend = 0;
    else if (w && !was_walk) m_pend = 1;
  endtask

  function automatic logic [3:0] exp_lights2();
    logic [3:0] l;
    for (int p = 0; p < 2; p++)
      l[2*p +: 2] = (p == m_phase && m_seg == 0) ? 2'd1 : (p == m_phase && m_seg == 1) ? 2'd2 : 2'd3;
    return l;
  endfunction

  // four-phase unit without walk or extension is a fixed 36-cycle schedule of 9-cycle slots
  function automatic logic [12:0] exp_four(input int t);
    logic [7:0] l;
    int k, p, r;
    k = t % 36; p = k / 9; r = k % 9;
    for (int q = 0; q < 4; q++)
      l[2*q +: 2] = (q == p && r < 6) ? 2'd1 : (q == p && r < 8) ? 2'd2 : 2'd3;
    return {l, 1'b0, 3'(p), 1'b0};
  endfunction

  task automatic cycle(input logic [1:0] s, input logic w);
    logic [8:0] exp_m;
    logic [12:0] exp_4;
    @(negedge clk);
    reset = 1'b0;
    bus.sensor = s;
    bus.walk_req = w;
    bus4.sensor = 4'($urandom);
    bus4.walk_req = 1'b0;
    model_step(s, w);
    t4++;
    @(posedge clk);
    #1;
    exp_m = {exp_lights2(), 1'(m_seg == 3), 3'(m_phase), m_pend};
    checks++;
    if ({bus.lights, bus.walk_light, bus.phase, bus.walk_pending} !== exp_m) begin
      failures++;
      $display("FAIL main_cycle t=%0t got=%b exp=%b", $time,
               {bus.lights, bus.walk_light, bus.phase, bus.walk_pending}, exp_m);
    end
    exp_4 = exp_four(t4);
    checks++;
    if ({bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending} !== exp_4) begin
      failures++;
      $display("FAIL four_phase_cycle t=%0t got=%b exp=%b", $time,
               {bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending}, exp_4);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic run_green0(input int from, input int to, output int len);
    len = 1;
    for (int i = 0; i < 40; i++) begin
      cycle((i >= from && i <= to) ? 2'b01 : 2'b00, 1'b0);
      if (bus.lights[1:0] !== LIGHT_GRN) return;
      len++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.lights, bus.walk_light, bus.phase, bus.walk_pending,
         bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", {bus.lights, bus.walk_light, bus.phase,
               bus.walk_pending, bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending}, RESET_VEC);
    end
  endtask

  task automatic test_default_round();
    logic [3:0] seq[$];
    logic [3:0] pat[$];
    int ph_mid;
    apply_reset();
    seq.push_back(bus.lights);
    for (int i = 0; i < 18; i++) begin
      cycle(2'b00, 1'b0);
      seq.push_back(bus.lights);
      if (i == 8) ph_mid = bus.phase;
    end
    repeat (6) pat.push_back(4'b1101);
    repeat (2) pat.push_back(4'b1110);
    pat.push_back(4'b1111);
    repeat (6) pat.push_back(4'b0111);
    repeat (2) pat.push_back(4'b1011);
    pat.push_back(4'b1111);
    pat.push_back(4'b1101);
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (seq[i] !== pat[i]) begin
        failures++;
        $display("FAIL round_pattern idx=%0d got=%b exp=%b", i, seq[i], pat[i]);
      end
    end
    checks++;
    if (ph_mid !== 1 || bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL round_phase got=%0d,%0d exp=1,0", ph_mid, bus.phase);
    end
  endtask

  task automatic test_extension();
    int len;
    apply_reset();
    run_green0(5, 5, len);
    checks++;
    if (len !== 9) begin failures++; $display("FAIL ext_single got=%0d exp=9", len); end
    apply_reset();
    run_green0(0, 100, len);
    checks++;
    if (len !== 9) begin failures++; $display("FAIL ext_held got=%0d exp=9", len); end
    apply_reset();
    run_green0(4, 4, len);
    checks++;
    if (len !== 6) begin failures++; $display("FAIL ext_early got=%0d exp=6", len); end
  endtask

  task automatic test_walk();
    int wl;
    apply_reset();
    for (int i = 0; i < 40 && bus.phase !== 3'd1; i++) cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b1);
    checks++;
    if (bus.walk_pending !== 1'b1 || bus.phase !== 3'd1) begin
      failures++;
      $display("FAIL walk_latch got=%b/%0d exp=1/1", bus.walk_pending, bus.phase);
    end
    for (int i = 0; i < 40 && !bus.walk_light; i++) cycle(2'b00, 1'b0);
    wl = 0;
    for (int i = 0; i < 20 && bus.walk_light; i++) begin
      wl++;
      cycle(2'b00, 1'b0);
    end
    checks++;
    if (wl !== TW) begin failures++; $display("FAIL walk_length got=%0d exp=%0d", wl, TW); end
    checks++;
    if ({bus.lights, bus.phase, bus.walk_pending} !== {4'b1101, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL walk_exit got=%b exp=%b", {bus.lights, bus.phase, bus.walk_pending},
               {4'b1101, 3'd0, 1'b0});
    end
  endtask

  task automatic test_walk_held();
    bit served;
    apply_reset();
    for (int i = 0; i < 60 && !bus.walk_light; i++) cycle(2'b00, 1'b1);
    for (int i = 0; i < 20 && bus.walk_light; i++) cycle(2'b00, 1'b1);
    checks++;
    if (bus.walk_light !== 1'b0 || bus.walk_pending !== 1'b0) begin
      failures++;
      $display("FAIL walk_held got=%b%b exp=00", bus.walk_light, bus.walk_pending);
    end
    cycle(2'b00, 1'b1);
    checks++;
    if (bus.walk_pending !== 1'b1) begin
      failures++;
      $display("FAIL walk_after_exit got=%b exp=1", bus.walk_pending);
    end
    served = 0;
    for (int i = 0; i < 60 && !served; i++) begin
      cycle(2'b00, 1'b0);
      served = bus.walk_light;
    end
    checks++;
    if (!served) begin failures++; $display("FAIL walk_next_round got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    while (t4 < 25) cycle(2'($urandom), 1'b0);
    apply_reset();
    checks++;
    if ({bus.lights, bus.walk_light, bus.phase, bus.walk_pending,
         bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid_yellow got=%b exp=%b", {bus.lights, bus.walk_light, bus.phase,
               bus.walk_pending, bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending}, RESET_VEC);
    end
    for (int i = 0; i < 60 && !bus.walk_light; i++) cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b0);
    apply_reset();
    checks++;
    if ({bus.lights, bus.walk_light, bus.phase, bus.walk_pending,
         bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid_walk got=%b exp=%b", {bus.lights, bus.walk_light, bus.phase,
               bus.walk_pending, bus4.lights, bus4.walk_light, bus4.phase, bus4.walk_pending}, RESET_VEC);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++)
      cycle(2'($urandom), ($urandom_range(0, 15) == 0));
  endtask

  initial begin
    bus.sensor = '0;
    bus.walk_req = 1'b0;
    bus4.sensor = '0;
    bus4.walk_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_default_round();
    test_extension();
    test_walk();
    test_walk_held();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-phase intersection controller. It sequences NUM_PHASES conflicting approaches round-robin through green, yellow and all-red intervals. Each phase gets a one-shot green extension driven by its own vehicle sensor, and a latched pedestrian request inserts an all-red walk interval at the end of each round. It generalises the two-approach main/side cycle and uses the same 2-bit light encoding.

## Interface
Parameters:
- NUM_PHASES, 2: number of approaches; legal range 2..8.
- CNT_W, 6: interval counter width; must hold max(T_GREEN+T_EXT, T_WALK).
- T_GREEN, 6: base green length, cycles.
- T_EXT, 3: green extension length, cycles; 0 disables extension.
- T_YEL, 2: yellow length, cycles; must be ≥1.
- T_ALLRED, 1: all-red clearance length, cycles; must be ≥1.
- T_WALK, 5: pedestrian walk length, cycles; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- sensor  in  NUM_PHASES  vehicle present, one bit per phase.
- walk_req  in  1  pedestrian button, level or pulse.
- lights  out  2*NUM_PHASES  per-phase light; phase p occupies [2p+1:2p]. Encoding: 0 off, 1 green, 2 yellow, 3 red.
- walk_light  out  1  pedestrian walk lamp.
- phase  out  3  index of the current phase.
- walk_pending  out  1  walk request latched and not yet served.

## Operation
- States: GREEN, YELLOW, ALLRED, WALK.
- An interval counter cnt resets to 0 on every state change and increments each cycle otherwise.
- GREEN(p):
  - Light p shows green; all other lights show red.
  - Green length is len = T_GREEN, or T_GREEN+T_EXT when extended.
  - Extension: if cnt == T_GREEN-1, sensor[p]=1, T_EXT>0 and ext_used=0, then set ext_used. At most one extension per green.
  - When cnt == len-1, go to YELLOW.
- YELLOW(p): light p shows yellow, others red. When cnt == T_YEL-1, go to ALLRED.
- ALLRED: all lights red.
  - When cnt == T_ALLRED-1 and p < NUM_PHASES-1: go to GREEN(p+1).
  - When p == NUM_PHASES-1 and walk_pending=1: go to WALK.
  - Otherwise: go to GREEN(0).
- WALK: all lights red and walk_light=1. When cnt == T_WALK-1, go to GREEN(0) with phase=0.
- walk_pending:
  - Set on any cycle where walk_req=1 and state≠WALK.
  - Cleared on the edge that enters WALK.
  - If walk_req=1 and the WALK entry occur on the same edge, the request is not latched; requests made during WALK are ignored.
- ext_used clears on every entry to GREEN.
- Light value 0 (off) is never driven after reset.

## Timing
- Reset values:
  - state=GREEN, phase=0, cnt=0, ext_used=0, walk_pending=0.
  - lights: phase 0 = 1, all others = 3.
  - walk_light=0.
- Reset overrides all other activity on the same edge, including mid-interval and during WALK.
- All outputs are registered and change on the same edge as the state.
- Unextended green lasts exactly T_GREEN cycles; extended green lasts exactly T_GREEN+T_EXT cycles.
- Yellow, all-red and walk last exactly T_YEL, T_ALLRED and T_WALK cycles.
- A sensor change reaches its effect with a one-cycle sample; only the value at cnt == T_GREEN-1 matters.
- phase wraps from NUM_PHASES-1 to 0 after ALLRED (or after WALK).
- With NUM_PHASES=2 and T_ALLRED=1, a full round without walk or extension takes 2*(T_GREEN+T_YEL+1) cycles = 18 at the default parameters.

## Structure
- Shared package traffic_pkg:
  - Light constants LIGHT_OFF=0, LIGHT_GRN=1, LIGHT_YEL=2, LIGHT_RED=3.
  - State enum ST_GREEN, ST_YELLOW, ST_ALLRED, ST_WALK.
- One sub-module, interval_timer (CNT_W): inputs clr and target; outputs cnt and done = (cnt == target-1). The FSM drives target per state.
- Light decode is a registered per-phase loop inside traffic_phase_ctrl.

## Test plan
- Reset, defaults, no inputs → lights=4'b1101 for 6 cycles, then 4'b1110 for 2, then 4'b1111 for 1, then 4'b0111 for 6; phase advances 0→1→0; round takes 18 cycles.
- sensor[0]=1 at cnt=5 of phase-0 green → green lasts 9 cycles. Keep sensor[0] high → no second extension (9, not 12).
- walk_req pulse during phase 1 green → walk_pending=1; after phase 1 ALLRED, walk_light=1 with all lights red for 5 cycles; then phase 0 green and walk_pending=0.
- walk_req held through WALK → walk_pending stays 0 after WALK exits. Pulse on the WALK-exit cycle → latched, served the next round.
- NUM_PHASES=4, T_EXT=0 → phases 0..3 in order, each showing green 6 / yellow 2 / red-clearance 1; sensors have no effect.
- reset asserted mid-YELLOW of phase 2 and mid-WALK → next cycle matches reset values exactly, and walk_pending=0.
